fifo_sync_fwft: RTL and testbench

FIFO_SYNC_FWFT -- requirements
Module: fifo_sync_fwft

---
 rtl/fifo_pkg.sv | 13 +
 rtl/fifo_ram.sv | 25 ++
 rtl/fifo_sync_fwft.sv | 120 ++++++++++++
 tb/tb_fifo_sync_fwft.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types and helpers for the synchronous FIFO
package fifo_pkg;

    typedef enum logic {
        STD  = 1'b0,
        FWFT = 1'b1
    } read_mode_e;

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - WIDTH x DEPTH storage, one synchronous write port, one async read port
module fifo_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    // Contents are deliberately left unreset; occupancy tracking decides what is valid.
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_fwft.sv
// rtl/fifo_sync_fwft.sv - single-clock FIFO with standard or first-word-fall-through read
module fifo_sync_fwft
    import fifo_pkg::*;
#(
    parameter int         DEPTH             = 16,
    parameter int         WIDTH             = 32,
    parameter read_mode_e READ_MODE         = STD,
    parameter int         PROG_FULL_THRESH  = 12,
    parameter int         PROG_EMPTY_THRESH = 4
) (
    input  logic                     wr_clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         din,
    output logic                     full,
    output logic                     almost_full,
    output logic                     prog_full,
    output logic                     wr_ack,
    output logic                     overflow,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     almost_empty,
    output logic                     prog_empty,
    output logic                     data_valid,
    output logic                     underflow,
    output logic [$clog2(DEPTH):0]   data_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    localparam logic [CW-1:0] CNT_FULL   = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_AFULL  = CW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] CNT_PFULL  = CW'(PROG_FULL_THRESH);
    localparam logic [CW-1:0] CNT_PEMPTY = CW'(PROG_EMPTY_THRESH);

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "fifo_sync_fwft: DEPTH must be a power of two >= 4");
    end
    if (WIDTH < 1) begin : g_bad_width
        $fatal(1, "fifo_sync_fwft: WIDTH must be >= 1");
    end
    if (PROG_FULL_THRESH < 1 || PROG_FULL_THRESH > DEPTH) begin : g_bad_pfull
        $fatal(1, "fifo_sync_fwft: PROG_FULL_THRESH out of range 1..DEPTH");
    end
    if (PROG_EMPTY_THRESH < 0 || PROG_EMPTY_THRESH > DEPTH - 1) begin : g_bad_pempty
        $fatal(1, "fifo_sync_fwft: PROG_EMPTY_THRESH out of range 0..DEPTH-1");
    end

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] ram_rdata;
    logic [WIDTH-1:0] dout_q;
    logic             valid_q;
    logic             wr_acc;
    logic             rd_acc;

    // Accept decisions use the registered flags only, so a same-cycle read never
    // frees room for a write when full, nor a write feeds a read when empty.
    assign wr_acc = wr_en && !full  && !rst;
    assign rd_acc = rd_en && !empty && !rst;

    fifo_ram #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_ram (
        .clk   (wr_clk),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (din),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    always_ff @(posedge wr_clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            wr_ack    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            dout_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
                dout_q <= ram_rdata;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            wr_ack    <= wr_acc;
            overflow  <= wr_en && full;
            underflow <= rd_en && empty;
            valid_q   <= rd_acc;
        end
    end

    assign data_count   = count;
    assign full         = (count == CNT_FULL);
    assign almost_full  = (count == CNT_AFULL);
    assign prog_full    = (count >= CNT_PFULL);
    assign empty        = (count == '0);
    assign almost_empty = (count == CNT_ONE);
    assign prog_empty   = (count <= CNT_PEMPTY);

    // FWFT shows the head straight from the array; it reads as zero while empty.
    assign dout       = (READ_MODE == FWFT) ? (empty ? '0 : ram_rdata) : dout_q;
    assign data_valid = (READ_MODE == FWFT) ? !empty : valid_q;

endmodule

// File: tb/tb_fifo_sync_fwft.sv
// tb/tb_fifo_sync_fwft.sv - scoreboard bench driving STD and FWFT instances in lockstep
module tb_fifo_sync_fwft;

    localparam int DEPTH = 16;
    localparam int WIDTH = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             wr_clk = 1'b0;
    logic             rst    = 1'b1;
    logic             wr_en  = 1'b0;
    logic             rd_en  = 1'b0;
    logic [WIDTH-1:0] din    = '0;

    logic             s_full, s_afull, s_pfull, s_ack, s_ovf, s_empty, s_aempty, s_pempty, s_valid, s_unf;
    logic [WIDTH-1:0] s_dout;
    logic [CW-1:0]    s_count;
    logic             f_full, f_afull, f_pfull, f_ack, f_ovf, f_empty, f_aempty, f_pempty, f_valid, f_unf;
    logic [WIDTH-1:0] f_dout;
    logic [CW-1:0]    f_count;

    always #5 wr_clk = ~wr_clk;

    fifo_sync_fwft #(.DEPTH(DEPTH), .WIDTH(WIDTH), .READ_MODE(fifo_pkg::STD),
                     .PROG_FULL_THRESH(12), .PROG_EMPTY_THRESH(4)) u_std (
        .wr_clk(wr_clk), .rst(rst), .wr_en(wr_en), .din(din),
        .full(s_full), .almost_full(s_afull), .prog_full(s_pfull),
        .wr_ack(s_ack), .overflow(s_ovf), .rd_en(rd_en), .dout(s_dout),
        .empty(s_empty), .almost_empty(s_aempty), .prog_empty(s_pempty),
        .data_valid(s_valid), .underflow(s_unf), .data_count(s_count)
    );

    fifo_sync_fwft #(.DEPTH(DEPTH), .WIDTH(WIDTH), .READ_MODE(fifo_pkg::FWFT),
                     .PROG_FULL_THRESH(12), .PROG_EMPTY_THRESH(4)) u_fwft (
        .wr_clk(wr_clk), .rst(rst), .wr_en(wr_en), .din(din),
        .full(f_full), .almost_full(f_afull), .prog_full(f_pfull),
        .wr_ack(f_ack), .overflow(f_ovf), .rd_en(rd_en), .dout(f_dout),
        .empty(f_empty), .almost_empty(f_aempty), .prog_empty(f_pempty),
        .data_valid(f_valid), .underflow(f_unf), .data_count(f_count)
    );

    int errors = 0;
    int checks = 0;

    logic [WIDTH-1:0] sb[$];
    int               m_cnt   = 0;
    logic             m_ack   = 1'b0;
    logic             m_ovf   = 1'b0;
    logic             m_unf   = 1'b0;
    logic             m_valid = 1'b0;
    logic [WIDTH-1:0] m_dout  = '0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // One clock: apply inputs, advance the reference model, compare both instances.
    task automatic cyc(input logic w, input logic [WIDTH-1:0] d, input logic r, input logic rs);
        logic wacc, racc;
        logic [WIDTH-1:0] f_exp;
        wr_en = w; din = d; rd_en = r; rst = rs;
        @(posedge wr_clk);
        #1;
        if (rs) begin
            m_cnt = 0; sb.delete();
            m_ack = 0; m_ovf = 0; m_unf = 0; m_valid = 0; m_dout = '0;
        end else begin
            wacc    = w && (m_cnt != DEPTH);
            racc    = r && (m_cnt != 0);
            m_ack   = wacc;
            m_ovf   = w && !wacc;
            m_unf   = r && !racc;
            m_valid = racc;
            if (racc) m_dout = sb.pop_front();
            if (wacc) sb.push_back(d);
            m_cnt = m_cnt + int'(wacc) - int'(racc);
        end
        f_exp = (sb.size() > 0) ? sb[0] : '0;
        check("s_count",  32'(s_count),  32'(m_cnt));
        check("s_full",   32'(s_full),   32'(m_cnt == DEPTH));
        check("s_afull",  32'(s_afull),  32'(m_cnt == DEPTH - 1));
        check("s_pfull",  32'(s_pfull),  32'(m_cnt >= 12));
        check("s_empty",  32'(s_empty),  32'(m_cnt == 0));
        check("s_aempty", 32'(s_aempty), 32'(m_cnt == 1));
        check("s_pempty", 32'(s_pempty), 32'(m_cnt <= 4));
        check("s_ack",    32'(s_ack),    32'(m_ack));
        check("s_ovf",    32'(s_ovf),    32'(m_ovf));
        check("s_unf",    32'(s_unf),    32'(m_unf));
        check("s_valid",  32'(s_valid),  32'(m_valid));
        check("s_dout",   s_dout,        m_dout);
        check("f_count",  32'(f_count),  32'(m_cnt));
        check("f_empty",  32'(f_empty),  32'(m_cnt == 0));
        check("f_full",   32'(f_full),   32'(m_cnt == DEPTH));
        check("f_ack",    32'(f_ack),    32'(m_ack));
        check("f_ovf",    32'(f_ovf),    32'(m_ovf));
        check("f_unf",    32'(f_unf),    32'(m_unf));
        check("f_valid",  32'(f_valid),  32'(m_cnt != 0));
        check("f_dout",   f_dout,        f_exp);
    endtask

    initial begin
        cyc(0, '0, 0, 1);
        cyc(0, '0, 0, 1);
        cyc(0, '0, 0, 0);

        for (int i = 1; i <= 16; i++) cyc(1, WIDTH'(i), 0, 0);
        cyc(1, 32'hAA, 0, 0);
        for (int i = 0; i < 16; i++) cyc(0, '0, 1, 0);
        cyc(0, '0, 1, 0);
        cyc(0, '0, 0, 0);

        cyc(1, 32'h55, 0, 0);
        cyc(0, '0, 0, 0);
        cyc(0, '0, 1, 0);
        cyc(0, '0, 0, 0);

        for (int i = 0; i < 10; i++) cyc(1, 32'h100 + WIDTH'(i), 0, 0);
        for (int i = 0; i < 10; i++) cyc(0, '0, 1, 0);
        for (int i = 0; i < 10; i++) cyc(1, 32'h200 + WIDTH'(i), 0, 0);
        for (int i = 0; i < 20; i++) cyc(1, 32'h300 + WIDTH'(i), 1, 0);
        for (int i = 0; i < 3; i++)  cyc(0, '0, 1, 0);

        cyc(1, 32'hDEAD, 0, 1);
        cyc(0, '0, 0, 0);

        for (int i = 0; i < 16; i++) cyc(1, 32'h400 + WIDTH'(i), 0, 0);
        cyc(1, 32'hBEEF, 1, 0);
        for (int i = 0; i < 15; i++) cyc(0, '0, 1, 0);
        cyc(1, 32'h600D, 1, 0);
        cyc(0, '0, 1, 0);
        cyc(0, '0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
